// File: rtl/pwm_pkg.sv
// Shared constants for the 16-channel PWM peripheral: counter width, full-duty
// code and the default prescaler ratio.
package pwm_pkg;

  localparam int PWM_CNT_W = 8;
  localparam logic [PWM_CNT_W-1:0] DUTY_FULL = 8'hFF;
  localparam logic [PWM_CNT_W-1:0] CNT_LAST = 8'hFF;
  localparam int PRESCALE_DIV_DEFAULT = 10;
  localparam int OUT_W = 16;

  // Duty 0xFF is forced high so the last count of a period never dips low.
  function automatic logic pwm_level_f(input logic [PWM_CNT_W-1:0] cnt,
                                       input logic [PWM_CNT_W-1:0] duty);
    return (duty == DUTY_FULL) || (cnt < duty);
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Free-running clk divider: tick is high for one clk every DIV clks,
// in the clk where the internal count sits at DIV-1.
module pwm_prescaler #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pwm_peripheral.sv
// 16-output PWM peripheral: one shared 8-bit PWM counter, a duty register
// shadowed at each period boundary, and per-bit enable / PWM-mode selection.
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int PRESCALE_DIV = PRESCALE_DIV_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       en_reg_out_7_0,
  input  logic [7:0]       en_reg_out_15_8,
  input  logic [7:0]       en_reg_pwm_7_0,
  input  logic [7:0]       en_reg_pwm_15_8,
  input  logic [7:0]       pwm_duty_cycle,
  output logic [OUT_W-1:0] out,
  output logic             period_start
);

  logic                 tick;
  logic                 boundary;
  logic                 pwm_level;
  logic [OUT_W-1:0]     en_all;
  logic [OUT_W-1:0]     pwm_sel;

  logic [PWM_CNT_W-1:0] pwm_cnt_q;
  logic [PWM_CNT_W-1:0] pwm_cnt_d;
  logic [PWM_CNT_W-1:0] duty_shadow_q;
  logic [PWM_CNT_W-1:0] duty_shadow_d;
  logic [OUT_W-1:0]     out_q;
  logic [OUT_W-1:0]     out_d;
  logic                 period_start_q;
  logic                 period_start_d;

  pwm_prescaler #(
    .DIV (PRESCALE_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign en_all  = {en_reg_out_15_8, en_reg_out_7_0};
  assign pwm_sel = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  // The level is taken from the next-state counter and shadow so that the
  // registered out and period_start both land on the first clk of count 0x00.
  always_comb begin
    boundary       = tick && (pwm_cnt_q == CNT_LAST);
    pwm_cnt_d      = tick ? pwm_cnt_q + PWM_CNT_W'(1) : pwm_cnt_q;
    duty_shadow_d  = boundary ? pwm_duty_cycle : duty_shadow_q;
    pwm_level      = pwm_level_f(pwm_cnt_d, duty_shadow_d);
    out_d          = en_all & (~pwm_sel | {OUT_W{pwm_level}});
    period_start_d = boundary;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q      <= '0;
      duty_shadow_q  <= '0;
      out_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      pwm_cnt_q      <= pwm_cnt_d;
      duty_shadow_q  <= duty_shadow_d;
      out_q          <= out_d;
      period_start_q <= period_start_d;
    end
  end

  assign out          = out_q;
  assign period_start = period_start_q;

endmodule

// File: doc/pwm_peripheral.md
PWM_PERIPHERAL -- requirements
Module: pwm_peripheral

Interface
REQ-001 The block SHALL have parameter PRESCALE_DIV, default 10, giving the clk cycles per PWM count tick (legal 1..65535).
REQ-002 The block SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-004 The block SHALL have port en_reg_out_7_0, input, 8, output enable for out[7:0].
REQ-005 The block SHALL have port en_reg_out_15_8, input, 8, output enable for out[15:8].
REQ-006 The block SHALL have port en_reg_pwm_7_0, input, 8, PWM mode select for out[7:0].
REQ-007 The block SHALL have port en_reg_pwm_15_8, input, 8, PWM mode select for out[15:8].
REQ-008 The block SHALL have port pwm_duty_cycle, input, 8, requested duty (0x00 = 0 %, 0xFF = 100 %).
REQ-009 The block SHALL have port out, output, 16, registered drive: [7:0] to uo_out, [15:8] to uio_out.
REQ-010 The block SHALL have port period_start, output, 1, one-clk pulse at each PWM period boundary.

Function
REQ-011 Prescaler SHALL count 0..PRESCALE_DIV-1 and wrap to 0; tick SHALL be high for the one clk in which the count equals PRESCALE_DIV-1; PRESCALE_DIV=1 SHALL give a tick every clk.
REQ-012 8-bit pwm_cnt SHALL increment by 1 on each tick, wrap 0xFF->0x00, and hold otherwise.
REQ-013 Period boundary SHALL be the clk in which tick is high and pwm_cnt = 0xFF; one period = 256*PRESCALE_DIV clk.
REQ-014 At each period boundary duty_shadow SHALL load pwm_duty_cycle as sampled that clk; mid-period changes of pwm_duty_cycle SHALL NOT affect the running period (glitch-free update).
REQ-015 pwm_level SHALL be 1 when duty_shadow = 0xFF, else (pwm_cnt < duty_shadow); duty 0x00 gives constant 0, duty 0xFF gives constant 1, duty N gives N high counts per 256.
REQ-016 For each bit i: out[i] SHALL be 0 if enable bit i = 0; pwm_level if enable = 1 and PWM select = 1; constant 1 if enable = 1 and PWM select = 0.
REQ-017 out SHALL be registered: one clk latency from pwm_cnt/duty_shadow/enable inputs to out.
REQ-018 Enable and PWM-select inputs SHALL NOT be shadowed; a change SHALL appear on out exactly one clk later.
REQ-019 period_start SHALL be registered and high for exactly the clk after each period boundary, aligned with out showing pwm_cnt = 0x00.
REQ-020 Inputs SHALL be treated as synchronous to clk (produced by the clk-domain register file); no further synchronisers inside.

Reset
REQ-021 On rst_n low, prescaler count, pwm_cnt, duty_shadow, out and period_start SHALL go to 0 immediately, independent of clk.
REQ-022 After reset release, first tick SHALL occur PRESCALE_DIV clk later; duty_shadow SHALL remain 0x00 (outputs in PWM mode low) until the first period boundary.
REQ-023 Reset asserted mid-period SHALL abandon the period; no partial pulse SHALL follow release.

Structure
REQ-024 A package pwm_pkg SHALL hold PWM_CNT_W = 8, DUTY_FULL = 8'hFF and the PRESCALE_DIV default.
REQ-025 The prescaler SHALL be a sub-module pwm_prescaler (inputs clk, rst_n; output tick; parameter DIV).
REQ-026 The per-bit output mux SHALL be a 16-wide vector expression, not 16 instances.

Verification
REQ-027 Reset, PRESCALE_DIV=10, all enables 0xFF, PWM select 0xFFFF, duty 0x80 -> after first boundary each period: out = 0xFFFF for 1280 clk, 0x0000 for 1280 clk.
REQ-028 Duty 0x00 then 0xFF -> out constant 0x0000 for full period, then 0xFFFF continuously from the next boundary; no one-count low glitch at 0xFF.
REQ-029 Duty changed 0x40->0xC0 at pwm_cnt = 0x20 -> current period keeps 64 high counts; next period 192 high counts; period_start pulse marks the switch.
REQ-030 en_reg_out = 0x00FF, PWM select = 0x000F, duty 0x40 -> out[3:0] PWM, out[7:4] = 1, out[15:8] = 0; toggling en bit 5 low shows out[5]=0 one clk later.
REQ-031 PRESCALE_DIV=1, rst_n pulsed low at pwm_cnt = 0x90 -> out and period_start 0 immediately; next boundary exactly 256 clk after release.
